// File: rtl/insn_enc.sv
// insn_enc: RV32I instruction encoder.
// Packs opcode, register fields, funct fields and a signed immediate into
// one instruction word, and rejects immediates the format cannot represent.
// A rejected request still produces a normal result: the NOP word with err_o set.
// Two-stage valid/ready pipeline with full back-pressure.
// S1 holds the request and its format class. S2 holds the encoded word.
// Optional feature: define ENC_ERRCNT_EN to add a saturating reject counter
// (errcnt_o / errcnt_clr_i).
module insn_enc #(
    parameter int DWIDTH = 32
`ifdef ENC_ERRCNT_EN
    ,
    parameter int ERRCNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [DWIDTH-1:0] imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] insn_o,
`ifdef ENC_ERRCNT_EN
    output logic [ERRCNT_W-1:0] errcnt_o,
    input  logic                errcnt_clr_i,
`endif
    output logic              err_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

    fmt_t        in_fmt;
    fmt_t        s1_fmt;
    logic        s1_v;
    logic        s2_v;
    logic        s1_adv;
    logic        s2_adv;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic [6:0]  s1_f7;
    logic [31:0] s1_imm;
    logic [31:0] enc_insn;
    logic        enc_err;

    // Handshake: a stage moves when it is empty or its consumer takes the current entry.
    assign s2_adv      = !s2_v || out_ready_i;
    assign s1_adv      = !s1_v || s2_adv;
    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_v;

    // Classify the incoming opcode into its encoding format.
    always_comb begin
        in_fmt = FMT_BAD;
        case (opcode_i)
            OP_LUI, OP_AUIPC:                     in_fmt = FMT_U;
            OP_JAL:                               in_fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM: in_fmt = FMT_I;
            OP_STORE:                             in_fmt = FMT_S;
            OP_BRANCH:                            in_fmt = FMT_B;
            OP_OP:                                in_fmt = FMT_R;
            default:                              in_fmt = FMT_BAD;
        endcase
    end

    // Stage 1: capture the accepted request together with its format class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_fmt <= FMT_BAD;
            s1_op  <= '0;
            s1_rd  <= '0;
            s1_rs1 <= '0;
            s1_rs2 <= '0;
            s1_f3  <= '0;
            s1_f7  <= '0;
            s1_imm <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid_i;
            if (in_valid_i) begin
                s1_fmt <= in_fmt;
                s1_op  <= opcode_i;
                s1_rd  <= rd_i;
                s1_rs1 <= rs1_i;
                s1_rs2 <= rs2_i;
                s1_f3  <= funct3_i;
                s1_f7  <= funct7_i;
                s1_imm <= imm_i[31:0];
            end
        end
    end

    // Pack the fields for the stage-1 format and check that the immediate fits it.
    // Range checks compare the bits above the field with the field's sign bit.
    always_comb begin
        enc_insn = NOP;
        enc_err  = 1'b0;
        case (s1_fmt)
            FMT_U: begin
                enc_err  = s1_imm[11:0] != 12'h000;
                enc_insn = {s1_imm[31:12], s1_rd, s1_op};
            end
            FMT_J: begin
                enc_err  = s1_imm[0] || (s1_imm[31:20] != {12{s1_imm[20]}});
                enc_insn = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
            end
            FMT_I: begin
                if (s1_op == OP_OPIMM && s1_f3 == 3'b001) begin
                    enc_err = s1_imm[31:5] != 27'd0;
                end else if (s1_op == OP_OPIMM && s1_f3 == 3'b101) begin
                    enc_err = (s1_imm[31:11] != 21'd0) || (s1_imm[9:5] != 5'd0);
                end else begin
                    enc_err = s1_imm[31:11] != {21{s1_imm[11]}};
                end
                enc_insn = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
            end
            FMT_S: begin
                enc_err  = s1_imm[31:11] != {21{s1_imm[11]}};
                enc_insn = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
            end
            FMT_B: begin
                enc_err  = s1_imm[0] || (s1_imm[31:12] != {20{s1_imm[12]}});
                enc_insn = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                            s1_imm[4:1], s1_imm[11], s1_op};
            end
            FMT_R: begin
                enc_err  = 1'b0;
                enc_insn = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
            end
            default: begin
                enc_err  = 1'b1;
                enc_insn = NOP;
            end
        endcase
    end

    // Stage 2: register the result; a rejected request becomes a NOP with err_o set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            insn_o <= '0;
            err_o  <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                insn_o <= enc_err ? NOP : enc_insn;
                err_o  <= enc_err;
            end
        end
    end

`ifdef ENC_ERRCNT_EN
    // Count rejected results as the consumer takes them; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errcnt_o <= '0;
        end else if (errcnt_clr_i) begin
            errcnt_o <= '0;
        end else if (s2_v && out_ready_i && err_o && (errcnt_o != '1)) begin
            errcnt_o <= errcnt_o + ERRCNT_W'(1);
        end
    end
`endif

endmodule
